// File: rtl/matmul_pkg.sv
// Shared matmul definitions: write-back FSM states, default array geometry and Q-format widths.
package matmul_pkg;

    localparam int unsigned MM_N         = 64;
    localparam int unsigned MM_LANES     = 4;
    localparam int unsigned MM_ACC_WIDTH = 32;
    localparam int unsigned MM_FRAC_BITS = 8;

    localparam int unsigned Q_WIDTH     = 16;
    localparam int unsigned Q_FRAC_BITS = 8;
    localparam int unsigned Q_ADDR_W    = 12;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_ACCEPT,
        WB_WRITE,
        WB_DONE
    } wb_state_t;

endpackage

// File: rtl/output_writeback_if.sv
// Accumulator-vector input stream and result-memory write port of the write-back stage.
interface output_writeback_if
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Q_WIDTH,
    parameter int unsigned ADDR_WIDTH = Q_ADDR_W,
    parameter int unsigned LANES      = MM_LANES,
    parameter int unsigned ACC_WIDTH  = MM_ACC_WIDTH
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*ACC_WIDTH-1:0]   in_data;
    logic                         mem_en;
    logic                         mem_we;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]        mem_din;

    // master: the write-back stage itself
    modport master (
        input  in_valid, in_data,
        output in_ready, mem_en, mem_we, mem_addr, mem_din
    );

    // slave: compute array feeding vectors and the memory receiving words
    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_en, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/acc_to_q16.sv
// Floor-shift a signed accumulator by FRAC_BITS and narrow it to DATA_WIDTH.
// OUTPUT_WB_SAT_EN selects clamping; otherwise the low bits are kept (wrap).
module acc_to_q16 #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] q
);
    logic [ACC_WIDTH-1:0] shifted;

    assign shifted = $unsigned($signed(acc) >>> FRAC_BITS);

`ifdef OUTPUT_WB_SAT_EN
    logic [ACC_WIDTH-DATA_WIDTH:0] hi;

    assign hi = shifted[ACC_WIDTH-1:DATA_WIDTH-1];

    // In range exactly when the bits above the target sign bit are pure sign extension
    always_comb begin
        q = shifted[DATA_WIDTH-1:0];
        if (hi != '0 && hi != '1) begin
            q = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_shift_hi;

    assign unused_shift_hi = ^shifted[ACC_WIDTH-1:DATA_WIDTH];
    assign q               = shifted[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/output_writeback.sv
// Drains accumulator vectors into the N x N result memory, one converted lane per cycle, row-major.
// Optional clamping of narrowed words: OUTPUT_WB_SAT_EN (see acc_to_q16).
module output_writeback
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Q_WIDTH,
    parameter int unsigned ADDR_WIDTH = Q_ADDR_W,
    parameter int unsigned N          = MM_N,
    parameter int unsigned LANES      = MM_LANES,
    parameter int unsigned ACC_WIDTH  = MM_ACC_WIDTH,
    parameter int unsigned FRAC_BITS  = MM_FRAC_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output_writeback_if.master     wb,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    wb_state_t                  state_q, state_n;
    logic [CW-1:0]              row_q, row_n, col_q, col_n;
    logic [LW-1:0]              lane_q, lane_n, lane_idx;
    logic [LANES*ACC_WIDTH-1:0] buf_q, buf_n;
    logic                       last_q, last_n;
    logic                       busy_n, done_n, in_ready_n, mem_en_n;
    logic [ADDR_WIDTH-1:0]      addr_n;
    logic [DATA_WIDTH-1:0]      din_n;
    logic                       load, issue, final_elem;
    logic [ACC_WIDTH-1:0]       conv_acc;
    logic [DATA_WIDTH-1:0]      conv_q;

    // A fresh vector's lane 0 is converted straight from in_data so it is written with no bubble
    assign lane_idx = load ? '0 : lane_q;
    assign conv_acc = load ? wb.in_data[ACC_WIDTH-1:0]
                           : buf_q[int'(lane_q)*ACC_WIDTH +: ACC_WIDTH];

    acc_to_q16 #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_conv (
        .acc (conv_acc),
        .q   (conv_q)
    );

    assign final_elem = (row_q == CW'(N-1)) && (col_q == CW'(N-1));

    always_comb begin
        state_n    = state_q;
        row_n      = row_q;
        col_n      = col_q;
        lane_n     = lane_q;
        buf_n      = buf_q;
        last_n     = last_q;
        busy_n     = busy;
        done_n     = 1'b0;
        in_ready_n = 1'b0;
        mem_en_n   = 1'b0;
        addr_n     = wb.mem_addr;
        din_n      = wb.mem_din;
        load       = 1'b0;
        issue      = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (start) begin
                    row_n      = '0;
                    col_n      = '0;
                    lane_n     = '0;
                    last_n     = 1'b0;
                    busy_n     = 1'b1;
                    in_ready_n = 1'b1;
                    state_n    = WB_ACCEPT;
                end
            end
            WB_ACCEPT: begin
                if (wb.in_valid) load = 1'b1;
                else             in_ready_n = 1'b1;
            end
            WB_WRITE: begin
                // Registered outputs present the write issued on the previous edge
                if (last_q) begin
                    done_n  = 1'b1;
                    state_n = WB_DONE;
                end else if (wb.in_ready) begin
                    if (wb.in_valid) begin
                        load = 1'b1;
                    end else begin
                        in_ready_n = 1'b1;
                        state_n    = WB_ACCEPT;
                    end
                end else begin
                    issue = 1'b1;
                end
            end
            WB_DONE: begin
                busy_n  = 1'b0;
                state_n = WB_IDLE;
            end
            default: state_n = WB_IDLE;
        endcase

        if (load || issue) begin
            if (load) buf_n = wb.in_data;
            mem_en_n   = 1'b1;
            addr_n     = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(N) + ADDR_WIDTH'(col_q);
            din_n      = conv_q;
            lane_n     = (lane_idx == LW'(LANES-1)) ? '0 : lane_idx + 1'b1;
            last_n     = final_elem;
            in_ready_n = (lane_idx == LW'(LANES-1)) && !final_elem;
            state_n    = WB_WRITE;
            if (col_q == CW'(N-1)) begin
                col_n = '0;
                row_n = row_q + 1'b1;
            end else begin
                col_n = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WB_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
            last_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wb.in_ready <= 1'b0;
            wb.mem_en   <= 1'b0;
            wb.mem_we   <= 1'b0;
            wb.mem_addr <= '0;
            wb.mem_din  <= '0;
        end else begin
            state_q     <= state_n;
            row_q       <= row_n;
            col_q       <= col_n;
            lane_q      <= lane_n;
            buf_q       <= buf_n;
            last_q      <= last_n;
            busy        <= busy_n;
            done        <= done_n;
            wb.in_ready <= in_ready_n;
            wb.mem_en   <= mem_en_n;
            wb.mem_we   <= mem_en_n;
            wb.mem_addr <= addr_n;
            wb.mem_din  <= din_n;
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
// Scoreboard bench for output_writeback: directed vectors, expected writes queued at issue time.
module tb_output_writeback;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned N  = 64;
    localparam int unsigned L  = 4;
    localparam int unsigned AC = 32;
    localparam int unsigned FB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    output_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(L), .ACC_WIDTH(AC)) wb ();

    output_writeback #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .N          (N),
        .LANES      (L),
        .ACC_WIDTH  (AC),
        .FRAC_BITS  (FB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .wb    (wb.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } exp_t;

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    logic          expect_contig = 1'b0;
    logic [AW-1:0] next_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic send_vec(input logic [L*AC-1:0] d, input logic [L*DW-1:0] e);
        int unsigned n;
        for (int k = 0; k < L; k++) begin
            q.push_back({next_addr, e[k*DW +: DW]});
            next_addr = next_addr + 1'b1;
        end
        wb.in_valid = 1'b1;
        wb.in_data  = d;
        n = 0;
        while (!wb.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            errors++;
            checks++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 1000 cycles");
        end
        @(negedge clk);
    endtask

    // lane k carries (base + 4v + k) << FRAC_BITS, which converts back to base + 4v + k
    task automatic pattern_vec(input int unsigned v, input int unsigned base);
        logic [L*AC-1:0] d;
        logic [L*DW-1:0] e;
        for (int k = 0; k < L; k++) begin
            d[k*AC +: AC] = AC'(base + v*L + k) << FB;
            e[k*DW +: DW] = DW'(base + v*L + k);
        end
        send_vec(d, e);
    endtask

    task automatic do_start();
        next_addr = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", wb.in_ready, 1);
    endtask

    task automatic wait_done();
        int unsigned n;
        wb.in_valid = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got 0 expected 1 within 200 cycles");
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    // Monitor: pop and compare on every write; check done placement
    initial begin
        exp_t        e;
        int unsigned nwr = 0;
        int unsigned first_cyc = 0;
        int unsigned last_cyc = 0;
        forever begin
            @(negedge clk);
            if (wb.mem_en) begin
                chk("mem_we", wb.mem_we, 1);
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, none expected", wb.mem_addr, wb.mem_din);
                end else begin
                    e = q.pop_front();
                    chk("mem_addr", wb.mem_addr, e.addr);
                    chk("mem_din", wb.mem_din, e.din);
                end
                if (wb.in_ready) chk("in_ready_lane", wb.mem_addr % L, L-1);
                if (nwr == 0) first_cyc = cyc;
                nwr++;
                last_cyc = cyc;
            end
            if (done) begin
                chk("done_after_last", cyc - last_cyc, 1);
                chk("done_queue_empty", q.size(), 0);
                chk("done_busy", busy, 1);
                if (expect_contig) chk("contig_span", cyc - first_cyc, nwr);
            end
            if (!busy) nwr = 0;
        end
    end

    initial begin
        logic [L*AC-1:0] d;
        logic [L*DW-1:0] e;
        wb.in_valid = 1'b0;
        wb.in_data  = '0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", wb.in_ready, 0);
        chk("rst_mem_en", wb.mem_en, 0);
        chk("rst_mem_we", wb.mem_we, 0);
        chk("rst_mem_addr", wb.mem_addr, 0);
        chk("rst_mem_din", wb.mem_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full matrix, back-to-back vectors
        expect_contig = 1'b1;
        do_start();
        for (int unsigned v = 0; v < N*N/L; v++) pattern_vec(v, 0);
        wb.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_addr", wb.mem_addr, N*N-1);
        chk("final_no_ready", wb.in_ready, 0);
        wait_done();
        expect_contig = 1'b0;

        // Conversion corners, then 3-cycle gaps for the first vectors
        do_start();
        d = {32'hFF00_0000, 32'h7FFF_FF00, 32'hFFFF_FF80, 32'h0000_0180};
`ifdef OUTPUT_WB_SAT_EN
        e = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
`else
        e = {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001};
`endif
        for (int unsigned v = 0; v < N*N/L; v++) begin
            if (v == 0) send_vec(d, e);
            else        pattern_vec(v, 16'h0100);
            if (v < 16) begin
                wb.in_valid = 1'b0;
                repeat (3) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("gap_in_ready", wb.in_ready, 1);
                    chk("gap_mem_en", wb.mem_en, 0);
                end
            end
        end
        wait_done();

        // Reset mid-matrix while address 10 is being written
        do_start();
        for (int unsigned v = 0; v < 3; v++) pattern_vec(v, 16'h0200);
        wb.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_addr", wb.mem_addr, 10);
        chk("pre_rst_en", wb.mem_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_en", wb.mem_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", wb.in_ready, 0);
        chk("mid_rst_addr", wb.mem_addr, 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", wb.mem_en, 0);

        // Restart from address 0; a start pulse mid-matrix is ignored
        do_start();
        for (int unsigned v = 0; v < N*N/L; v++) begin
            if (v == 100) start = 1'b1;
            pattern_vec(v, 16'h0300);
            if (v == 100) start = 1'b0;
        end
        wait_done();

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/output_writeback.md
# output_writeback

Write-back stage that drains fixed-point accumulator vectors from the matmul compute array into the output result memory through its single-word write port. It converts each signed accumulator lane to a 16-bit Q-format word and serializes lanes into row-major addresses covering an N×N result matrix. It signals completion so the host side can read the finished matrix back over the 32-bit AXI-facing port.

## Interface
- DATA_WIDTH, 16, output word width (memory write port width)
- ADDR_WIDTH, 12, memory word address width; 2^ADDR_WIDTH == N*N
- N, 64, matrix dimension; must be a multiple of LANES
- LANES, 4, accumulator lanes per input vector
- ACC_WIDTH, 32, signed accumulator width per lane
- FRAC_BITS, 8, right-shift applied to accumulators before narrowing

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new matrix write-back
- in_valid  in  1  input vector valid
- in_ready  out  1  stage can accept a vector this cycle
- in_data  in  LANES*ACC_WIDTH  lane k at bits [k*ACC_WIDTH +: ACC_WIDTH]; lane 0 written first
- mem_en  out  1  memory enable (drives en_b)
- mem_we  out  1  write enable (drives we_b); always equal to mem_en
- mem_addr  out  ADDR_WIDTH  word address (drives addr_b)
- mem_din  out  DATA_WIDTH  converted word (drives din_b)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after final write

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: start -> clear row, col, lane counters; go ACCEPT. start in any other state ignored.
- ACCEPT: in_ready=1; in_valid&in_ready latches in_data into lane buffer, lane=0, go WRITE.
- WRITE: one write per cycle, lane k: mem_addr=row*N+col, mem_din=convert(lane k). col increments; col==N-1 wraps to 0 and row increments.
- in_ready also high in WRITE on lane LANES-1 unless that write is element N*N-1; handshake there reloads buffer and stays in WRITE (back-to-back, no bubble). No handshake there -> ACCEPT.
- Final write (row==N-1, col==N-1) -> DONE; DONE asserts done for one cycle -> IDLE.
- convert: arithmetic shift right by FRAC_BITS (floor), then narrow to DATA_WIDTH per Configuration.
- Address arithmetic is ADDR_WIDTH bits; never exceeds N*N-1.

## Timing
- All outputs registered. Reset values: in_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0; state IDLE.
- start sampled at edge t -> busy=1 and in_ready=1 from t+1.
- Handshake at edge t -> mem_en high for cycles t+1 … t+LANES, one lane per cycle.
- Sustained throughput: one vector per LANES cycles; full matrix N*N cycles of writes.
- done high the cycle after the last mem_en cycle; busy falls with done's falling edge.
- rst_n low mid-operation: immediately clears all outputs and counters; partial matrix abandoned, no further writes.
- in_valid held with in_ready low: data must be held stable; no writes issued.

## Configuration
- OUTPUT_WB_SAT_EN defined: narrowed value clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: narrowed value is the low DATA_WIDTH bits of the shifted accumulator (wrap).

## Structure
- Shared package matmul_pkg: wb_state_t enum, default N/LANES/ACC_WIDTH/FRAC_BITS constants, Q-format width constants.
- One sub-module: acc_to_q16, combinational shift-and-narrow converter, honouring OUTPUT_WB_SAT_EN.

## Test plan
- Reset, start, 1024 back-to-back vectors of lane value (index<<8) -> 4096 writes, addr 0…4095 in order, din=index, no idle cycles, done one cycle after addr 4095.
- Lane 0x0000_0180 -> din 0x0001; lane 0xFFFF_FF80 -> din 0xFFFF (floor).
- Lane 0x7FFF_FF00: with OUTPUT_WB_SAT_EN din 0x7FFF, without 0xFFFF; lane 0xFF00_0000: with 0x8000, without 0x0000.
- in_valid gaps of 3 cycles between vectors -> mem_en low during gaps, addresses contiguous, in_ready high only in ACCEPT/last lane.
- Vector at row 0 col 60 -> writes 60…63, next vector writes 64 (row 1 col 0).
- rst_n low during write of addr 10 -> mem_en drops immediately; new start rewrites from addr 0; start pulse while busy has no effect.
